mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage load/store engine for the five-stage RISC-V pipeline. It consumes the EX/MEM register outputs (MemOp, MemRead, MemWrite, ALUResult, ReadData2) and drives a request/grant/response data-memory bus. It formats byte lanes, sign- or zero-extends load data for MEM/WB, and stalls the pipeline while an access is outstanding.

Parameters:
TIMEOUT_CYCLES, 64, max cycles spent in WAIT before a bus error is flagged
ADDR_W, 32, address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
flush  in  1  kill the current MEM-stage instruction
MemOp  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
MemRead  in  1  load request from EX/MEM
MemWrite  in  1  store request from EX/MEM
ALUResult  in  ADDR_W  byte address
ReadData2  in  32  store data
dmem_req  out  1  bus request
dmem_we  out  1  1 = write
dmem_addr  out  ADDR_W  word-aligned address (bits [1:0] = 0)
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-shifted store data
dmem_gnt  in  1  bus accepts the request this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read data
stall_mem  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
load_data  out  32  extended load result for MEM/WB
load_valid  out  1  load_data valid (one cycle)
misalign_exc  out  1  misaligned access pulse
bus_err  out  1  timeout pulse

Behaviour:
- Reset (reset = 0, async): state IDLE. All outputs 0, timeout counter 0.
- FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
- access = (MemRead | MemWrite) & ~flush. MemRead and MemWrite both 1 is treated as a store.
- Misaligned: H/HU with addr[0] = 1, or W with addr[1:0] != 0.
  - In IDLE, a misaligned access pulses misalign_exc for one cycle.
  - No bus request is issued and stall_mem stays 0.
- IDLE, aligned access: latch address, byte enables, wdata, MemOp and we; go to REQ.
  - stall_mem = 1 combinationally in this cycle.
- REQ: dmem_req = 1, outputs held stable until dmem_gnt.
  - On gnt, a write goes to DONE and a read goes to WAIT.
- WAIT: accept dmem_rvalid. The earliest rvalid is the cycle after gnt.
  - On rvalid: register the extended data and go to DONE.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES: pulse bus_err, load_data = 0, go to DONE.
- DONE: stall_mem = 0. For a read, load_valid = 1 with load_data for exactly one cycle.
  - EX/MEM still holds the same instruction this cycle, so DONE ignores its inputs and always returns to IDLE.
- stall_mem = 1 in REQ and WAIT, and in IDLE when an aligned access is present. Otherwise 0.
- Byte lanes (off = addr[1:0]):
  - B: be = 0001 << off, wdata = {4{ReadData2[7:0]}}.
  - H: be = 0011 << off, wdata = {2{ReadData2[15:0]}}.
  - W: be = 1111, wdata = ReadData2.
- Load extraction: select the byte/half at off from rdata. B/H sign-extend; BU/HU zero-extend; W passes through.
- Flush:
  - In IDLE: the access is ignored.
  - In REQ before gnt: drop the request and return to IDLE.
  - In WAIT: go to DRAIN, absorb the pending rvalid (or timeout) with no load_valid, then IDLE. stall_mem = 1 in DRAIN.
  - Flush is ignored in DONE.
- Simultaneous gnt and flush in REQ: the bus has committed, so go to DRAIN (read) or IDLE (write). No load_valid is produced.
- Reset mid-operation: immediate return to IDLE. The outstanding bus response is not tracked; the bus is reset alongside.
- dmem_rvalid outside WAIT/DRAIN is ignored.

Decomposition:
- Shared package: MemOp encodings (MEMOP_B/H/W/BU/HU) and FSM state enum, both reused by the decoder and MEM/WB.
- One natural sub-module, mem_lane_fmt (combinational): store lane/byte-enable generation and load extract/extend. The FSM and counter stay in the top.

Test Plan:
- SW addr 0x104, data 0xDEADBEEF, gnt on 2nd REQ cycle -> dmem_addr = 0x104, be = 1111, wdata = 0xDEADBEEF; stall high 3 cycles, DONE, no load_valid.
- LB addr 0x203, rdata 0x80FF_FF00 -> be = 1000, load_data = 0xFFFFFF80; LBU same -> 0x00000080; load_valid one cycle.
- LH addr 0x11, LW addr 0x22 -> misalign_exc pulse each, dmem_req never asserted, stall_mem 0.
- LW, rvalid withheld, TIMEOUT_CYCLES = 4 -> bus_err pulse after 4 WAIT cycles, load_data = 0, then IDLE.
- LW, flush asserted in WAIT, rvalid 2 cycles later -> DRAIN absorbs it, load_valid never set, IDLE next.
- SH addr 0x302 data 0x1234ABCD, reset driven low during REQ -> all outputs 0 immediately; after release, a new SH gives be = 1100, wdata = 0xABCDABCD.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: funct3 load/store encodings, FSM states and alignment check.
package mem_access_unit_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StDone,
    StDrain
  } mem_state_e;

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    logic mis;
    case (op)
      MEMOP_H, MEMOP_HU: mis = off[0];
      MEMOP_W:           mis = (off != 2'b00);
      default:           mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational byte-lane formatting: store enables/replication and load extract/extend.
module mem_lane_fmt
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  st_op_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [2:0]  ld_op_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // funct3[1:0] selects size; the unsigned bit is irrelevant for stores.
  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_op_i[1:0])
      2'b00: begin
        st_be_o    = 4'b0001 << st_off_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        st_be_o    = 4'b0011 << st_off_i;
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
  assign ld_half = ld_rdata_i[{ld_off_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_op_i)
      MEMOP_B:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      MEMOP_H:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      MEMOP_BU: ld_data_o = {24'd0, ld_byte};
      MEMOP_HU: ld_data_o = {16'd0, ld_half};
      default:  ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: drives the req/gnt/rvalid data bus and stalls the pipeline.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [2:0]        MemOp,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] ALUResult,
  input  logic [31:0]       ReadData2,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              stall_mem,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misalign_exc,
  output logic              bus_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        off_q, off_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        op_q, op_d;
  logic              we_q, we_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              bus_err_q, bus_err_d;

  logic        access, misaligned, timeout;
  logic [CntW-1:0] cnt_inc;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_ext;

  // Gated by reset so the combinational outputs also read 0 while reset is held.
  assign access     = (MemRead | MemWrite) & ~flush & reset;
  assign misaligned = is_misaligned(MemOp, ALUResult[1:0]);
  assign cnt_inc    = cnt_q + 1'b1;
  assign timeout    = (cnt_inc == CntW'(TIMEOUT_CYCLES));

  mem_lane_fmt u_lane_fmt (
    .st_op_i    (MemOp),
    .st_off_i   (ALUResult[1:0]),
    .st_data_i  (ReadData2),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata),
    .ld_op_i    (op_q),
    .ld_off_i   (off_q),
    .ld_rdata_i (dmem_rdata),
    .ld_data_o  (ld_ext)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    off_d        = off_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    load_data_d  = '0;
    load_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    stall_mem    = 1'b0;
    misalign_exc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (misaligned) begin
            misalign_exc = 1'b1;
          end else begin
            stall_mem = 1'b1;
            addr_d    = {ALUResult[ADDR_W-1:2], 2'b00};
            off_d     = ALUResult[1:0];
            be_d      = st_be;
            wdata_d   = st_wdata;
            op_d      = MemOp;
            we_d      = MemWrite;
            cnt_d     = '0;
            state_d   = StReq;
          end
        end
      end
      StReq: begin
        stall_mem = 1'b1;
        if (dmem_gnt) begin
          // A granted read is committed on the bus, so a flush must still drain it.
          if (flush) state_d = we_q ? StIdle : StDrain;
          else       state_d = we_q ? StDone : StWait;
        end else if (flush) begin
          state_d = StIdle;
        end
      end
      StWait: begin
        stall_mem = 1'b1;
        cnt_d     = cnt_inc;
        if (flush) begin
          state_d = (dmem_rvalid | timeout) ? StIdle : StDrain;
        end else if (dmem_rvalid) begin
          load_data_d  = ld_ext;
          load_valid_d = 1'b1;
          state_d      = StDone;
        end else if (timeout) begin
          bus_err_d    = 1'b1;
          load_valid_d = 1'b1;
          state_d      = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StDrain: begin
        stall_mem = 1'b1;
        cnt_d     = cnt_inc;
        if (dmem_rvalid | timeout) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      off_q        <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      op_q         <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      off_q        <= off_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign dmem_req   = (state_q == StReq);
  assign dmem_we    = dmem_req & we_q;
  assign dmem_addr  = dmem_req ? addr_q : '0;
  assign dmem_be    = dmem_req ? be_q : '0;
  assign dmem_wdata = dmem_req ? wdata_q : '0;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a load-result scoreboard.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset, flush, MemRead, MemWrite;
  logic [2:0]  MemOp;
  logic [31:0] ALUResult, ReadData2;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_mem, load_valid, misalign_exc, bus_err;
  logic [31:0] load_data;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          lv_count = 0;
  int          lv_before;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  mem_access_unit #(
    .TIMEOUT_CYCLES (4),
    .ADDR_W         (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .MemOp        (MemOp),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .ALUResult    (ALUResult),
    .ReadData2    (ReadData2),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .stall_mem    (stall_mem),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .misalign_exc (misalign_exc),
    .bus_err      (bus_err)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  // Scoreboard sink: every load_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    #2;
    if (load_valid === 1'b1) begin
      lv_count++;
      n_assert++;
      assert (exp_q.size() > 0)
      else begin
        n_fail++;
        $error("FAIL lv_unexpected: observed load_valid=1 data %h required no pulse", load_data);
      end
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        chk32("sb_load_data", load_data, mon_exp);
      end
    end
  end

  task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] be_exp,
                         input logic [31:0] rdata, input logic [31:0] exp);
    @(negedge clk);
    MemOp = op; ALUResult = addr; MemRead = 1'b1;
    #1 chk1("ld_idle_stall", stall_mem, 1'b1);
    @(negedge clk);
    #1;
    chk1("ld_req", dmem_req, 1'b1);
    chk1("ld_we", dmem_we, 1'b0);
    chk32("ld_addr", dmem_addr, {addr[31:2], 2'b00});
    chk32("ld_be", {28'd0, dmem_be}, {28'd0, be_exp});
    dmem_gnt = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    #1;
    chk1("ld_wait_stall", stall_mem, 1'b1);
    chk1("ld_wait_noreq", dmem_req, 1'b0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    chk1("ld_valid", load_valid, 1'b1);
    chk1("ld_done_stall", stall_mem, 1'b0);
    @(negedge clk);
    MemRead = 1'b0;
    #1 chk1("ld_valid_once", load_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemOp = 3'b000;
    ALUResult = '0; ReadData2 = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    #12;
    chk1("rst_req", dmem_req, 1'b0);
    chk1("rst_stall", stall_mem, 1'b0);
    chk1("rst_lv", load_valid, 1'b0);
    chk1("rst_berr", bus_err, 1'b0);
    chk32("rst_ldata", load_data, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // SW 0x104, grant on second REQ cycle
    @(negedge clk);
    MemWrite = 1'b1; MemOp = 3'b010; ALUResult = 32'h104; ReadData2 = 32'hDEADBEEF;
    #1;
    chk1("sw_idle_stall", stall_mem, 1'b1);
    chk1("sw_idle_noreq", dmem_req, 1'b0);
    @(negedge clk);
    #1;
    chk1("sw_req", dmem_req, 1'b1);
    chk1("sw_we", dmem_we, 1'b1);
    chk32("sw_addr", dmem_addr, 32'h104);
    chk32("sw_be", {28'd0, dmem_be}, 32'hF);
    chk32("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    chk1("sw_req_stall", stall_mem, 1'b1);
    @(negedge clk);
    dmem_gnt = 1'b1;
    #1;
    chk1("sw_req_hold", dmem_req, 1'b1);
    chk32("sw_addr_hold", dmem_addr, 32'h104);
    chk1("sw_req2_stall", stall_mem, 1'b1);
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1;
    chk1("sw_done_stall", stall_mem, 1'b0);
    chk1("sw_done_nolv", load_valid, 1'b0);
    chk1("sw_done_noreq", dmem_req, 1'b0);
    @(negedge clk);
    MemWrite = 1'b0;
    #1 chk1("sw_idle_after", stall_mem, 1'b0);

    // LB / LBU at byte 3
    do_load(3'b000, 32'h203, 4'b1000, 32'h80FF_FF00, 32'hFFFF_FF80);
    do_load(3'b100, 32'h203, 4'b1000, 32'h80FF_FF00, 32'h0000_0080);
    do_load(3'b101, 32'h202, 4'b1100, 32'h8001_0203, 32'h0000_8001);

    // Misaligned LH / LW
    @(negedge clk);
    MemRead = 1'b1; MemOp = 3'b001; ALUResult = 32'h11;
    #1;
    chk1("mis_lh_exc", misalign_exc, 1'b1);
    chk1("mis_lh_stall", stall_mem, 1'b0);
    chk1("mis_lh_req", dmem_req, 1'b0);
    @(negedge clk);
    MemOp = 3'b010; ALUResult = 32'h22;
    #1;
    chk1("mis_lw_exc", misalign_exc, 1'b1);
    chk1("mis_lw_stall", stall_mem, 1'b0);
    chk1("mis_lw_req", dmem_req, 1'b0);
    @(negedge clk);
    MemRead = 1'b0;
    #1;
    chk1("mis_exc_clear", misalign_exc, 1'b0);
    chk1("mis_noreq_after", dmem_req, 1'b0);

    // Flush in IDLE ignores the access
    @(negedge clk);
    MemRead = 1'b1; MemOp = 3'b010; ALUResult = 32'h60; flush = 1'b1;
    #1 chk1("fl_idle_stall", stall_mem, 1'b0);
    @(negedge clk);
    MemRead = 1'b0; flush = 1'b0;
    #1 chk1("fl_idle_noreq", dmem_req, 1'b0);

    // LW timeout (TIMEOUT_CYCLES = 4)
    @(negedge clk);
    MemRead = 1'b1; MemOp = 3'b010; ALUResult = 32'h40; dmem_rdata = 32'h5555_5555;
    @(negedge clk);
    dmem_gnt = 1'b1;
    exp_q.push_back(32'h0);
    #1 chk1("to_req", dmem_req, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dmem_gnt = 1'b0;
      #1;
      chk1("to_wait_stall", stall_mem, 1'b1);
      chk1("to_wait_noerr", bus_err, 1'b0);
    end
    @(negedge clk);
    #1;
    chk1("to_bus_err", bus_err, 1'b1);
    chk32("to_ldata", load_data, 32'h0);
    chk1("to_done_stall", stall_mem, 1'b0);
    @(negedge clk);
    MemRead = 1'b0;
    #1;
    chk1("to_err_pulse", bus_err, 1'b0);
    chk1("to_idle_noreq", dmem_req, 1'b0);

    // Flush during WAIT, rvalid two cycles later is absorbed
    lv_before = lv_count;
    @(negedge clk);
    MemRead = 1'b1; MemOp = 3'b010; ALUResult = 32'h50;
    @(negedge clk);
    dmem_gnt = 1'b1;
    #1 chk1("dr_req", dmem_req, 1'b1);
    @(negedge clk);
    dmem_gnt = 1'b0; flush = 1'b1;
    #1 chk1("dr_wait_stall", stall_mem, 1'b1);
    @(negedge clk);
    flush = 1'b0; MemRead = 1'b0;
    #1 chk1("dr_drain1_stall", stall_mem, 1'b1);
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
    #1 chk1("dr_drain2_stall", stall_mem, 1'b1);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    chk1("dr_idle_stall", stall_mem, 1'b0);
    chk1("dr_no_lv", load_valid, 1'b0);
    @(negedge clk);
    #2 chk32("dr_lv_count", 32'(lv_count), 32'(lv_before));

    // SH with reset mid-REQ, then a fresh SH
    @(negedge clk);
    MemWrite = 1'b1; MemOp = 3'b001; ALUResult = 32'h302; ReadData2 = 32'h1234_ABCD;
    #1 chk1("rs_idle_stall", stall_mem, 1'b1);
    @(negedge clk);
    #1;
    chk1("rs_req", dmem_req, 1'b1);
    chk32("rs_be", {28'd0, dmem_be}, 32'hC);
    #1 reset = 1'b0;
    #1;
    chk1("rs_async_req", dmem_req, 1'b0);
    chk1("rs_async_stall", stall_mem, 1'b0);
    chk32("rs_async_be", {28'd0, dmem_be}, 32'h0);
    chk32("rs_async_wdata", dmem_wdata, 32'h0);
    chk32("rs_async_addr", dmem_addr, 32'h0);
    @(negedge clk);
    MemWrite = 1'b0; reset = 1'b1;
    #1 chk1("rs_release_noreq", dmem_req, 1'b0);
    @(negedge clk);
    MemWrite = 1'b1;
    @(negedge clk);
    #1;
    chk1("rs2_req", dmem_req, 1'b1);
    chk32("rs2_addr", dmem_addr, 32'h300);
    chk32("rs2_be", {28'd0, dmem_be}, 32'hC);
    chk32("rs2_wdata", dmem_wdata, 32'hABCD_ABCD);
    dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_gnt = 1'b0;
    #1 chk1("rs2_done_stall", stall_mem, 1'b0);
    @(negedge clk);
    MemWrite = 1'b0;

    @(negedge clk);
    #3 chk32("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
